// File: rtl/config_frame_sequencer_pkg.sv
// Shared config-path types and constants for the config port block,
// the frame sequencer and the frame data registers.
package config_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } cfg_state_e;

   localparam int unsigned FrameBitsPerRow  = 32;
   localparam logic [31:0] SyncWordDefault  = 32'hFAB0_FAB1;
   localparam int unsigned DesyncBitDefault = 20;

endpackage

// File: rtl/config_frame_sequencer_if.sv
// Config word input and fabric frame-write outputs of the sequencer.
interface config_frame_sequencer_if #(
   parameter int unsigned RowSelectWidth = 5
);
   import config_pkg::*;

   logic [FrameBitsPerRow-1:0] WriteData;
   logic                       WriteStrobe;
   logic [31:0]                FrameAddressRegister;
   logic                       LongFrameStrobe;
   logic [RowSelectWidth-1:0]  RowSelect;
   logic [FrameBitsPerRow-1:0] RowWriteData;
   logic                       RowWriteStrobe;
   logic                       Active;
   logic [15:0]                FramesWritten;
   logic                       Error;

   modport slave (
      input  WriteData,
      input  WriteStrobe,
      output FrameAddressRegister,
      output LongFrameStrobe,
      output RowSelect,
      output RowWriteData,
      output RowWriteStrobe,
      output Active,
      output FramesWritten,
      output Error
   );

   modport master (
      output WriteData,
      output WriteStrobe,
      input  FrameAddressRegister,
      input  LongFrameStrobe,
      input  RowSelect,
      input  RowWriteData,
      input  RowWriteStrobe,
      input  Active,
      input  FramesWritten,
      input  Error
   );

endinterface

// File: rtl/config_frame_sequencer.sv
// Turns the config word stream into per-row frame writes and
// a closing LongFrameStrobe per completed frame.
module config_frame_sequencer
   import config_pkg::*;
#(
   parameter int unsigned NumberOfRows      = 16,
   parameter int unsigned RowSelectWidth    = 5,
   parameter int unsigned DesyncBit         = DesyncBitDefault,
   parameter logic [31:0] SyncWord          = SyncWordDefault,
   parameter logic [15:0] FramesWrittenInit = 16'h0000
) (
   input logic                      CLK,
   input logic                      reset,
   config_frame_sequencer_if.slave  bus
);

   localparam logic [RowSelectWidth-1:0] RowIdle = '1;
   localparam logic [RowSelectWidth-1:0] LastRow =
      RowSelectWidth'(NumberOfRows - 1);

   cfg_state_e                 state_q, state_d;
   logic                       acc_q, acc_d;
   logic                       err_q, err_d;
   logic [31:0]                far_q, far_d;
   logic [RowSelectWidth-1:0]  row_q, row_d;
   logic [RowSelectWidth-1:0]  rsel_q, rsel_d;
   logic [FrameBitsPerRow-1:0] rwd_q, rwd_d;
   logic                       rws_q, rws_d;
   logic                       last_q, last_d;
   logic                       lfs_q, lfs_d;
   logic [15:0]                frames_q, frames_d;

   logic stb, drop, is_sync, desync, last_row;
   logic ld_sync, ld_addr, wr_row;

   // a strobe right after an accepted one is dropped, not processed
   assign stb      = bus.WriteStrobe & ~acc_q;
   assign drop     = bus.WriteStrobe & acc_q;
   assign is_sync  = bus.WriteData == SyncWord;
   assign desync   = bus.WriteData[DesyncBit];
   assign last_row = row_q == LastRow;
   assign ld_sync  = stb & is_sync & (state_q == IDLE);
   assign ld_addr  = stb & ~desync & (state_q == ADDR);
   assign wr_row   = stb & (state_q == DATA);

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q  <= IDLE;
         acc_q    <= 1'b0;
         err_q    <= 1'b0;
         far_q    <= '0;
         row_q    <= '0;
         rsel_q   <= RowIdle;
         rwd_q    <= '0;
         rws_q    <= 1'b0;
         last_q   <= 1'b0;
         lfs_q    <= 1'b0;
         frames_q <= FramesWrittenInit;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         err_q    <= err_d;
         far_q    <= far_d;
         row_q    <= row_d;
         rsel_q   <= rsel_d;
         rwd_q    <= rwd_d;
         rws_q    <= rws_d;
         last_q   <= last_d;
         lfs_q    <= lfs_d;
         frames_q <= frames_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (ld_sync) state_d = ADDR;
         ADDR:    if (stb) state_d = desync ? IDLE : DATA;
         DATA:    if (stb && last_row) state_d = ADDR;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      acc_d    = stb & ((state_q != IDLE) | is_sync);
      err_d    = err_q;
      far_d    = far_q;
      row_d    = row_q;
      rwd_d    = rwd_q;
      rws_d    = 1'b0;
      last_d   = 1'b0;
      rsel_d   = (state_q == DATA) ? rsel_q : RowIdle;
      lfs_d    = last_q;
      frames_d = frames_q;
      if (last_q && frames_q != 16'hFFFF) frames_d = frames_q + 16'd1;
      unique case (1'b1)
         drop:    err_d = 1'b1;
         ld_sync: err_d = 1'b0;
         ld_addr: begin
            far_d = bus.WriteData;
            row_d = '0;
         end
         wr_row: begin
            rwd_d  = bus.WriteData;
            rsel_d = row_q;
            rws_d  = 1'b1;
            last_d = last_row;
            row_d  = last_row ? '0 : row_q + 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.FrameAddressRegister = far_q;
   assign bus.LongFrameStrobe      = lfs_q;
   assign bus.RowSelect            = rsel_q;
   assign bus.RowWriteData         = rwd_q;
   assign bus.RowWriteStrobe       = rws_q;
   assign bus.Active               = state_q != IDLE;
   assign bus.FramesWritten        = frames_q;
   assign bus.Error                = err_q;

endmodule

// File: tb/tb_config_frame_sequencer.sv
// Scoreboard bench: row/frame expectations queued at stimulus time,
// popped by a monitor whenever the DUT pulses a strobe.
module tb_config_frame_sequencer;
   import config_pkg::*;

   localparam int unsigned NR = 4;
   localparam logic [31:0] DESYNC = 32'h0010_0000;

   typedef struct {
      logic [4:0]  row;
      logic [31:0] data;
   } row_exp_t;

   typedef struct {
      logic [31:0] far;
      logic [15:0] frames;
   } frame_exp_t;

   logic clk = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 clk = ~clk;

   config_frame_sequencer_if #(.RowSelectWidth(5)) ifa ();
   config_frame_sequencer_if #(.RowSelectWidth(5)) ifb ();

   assign ifb.WriteData   = ifa.WriteData;
   assign ifb.WriteStrobe = ifa.WriteStrobe;

   config_frame_sequencer #(
      .NumberOfRows(NR)
   ) dut_a (
      .CLK(clk),
      .reset(rst_a),
      .bus(ifa)
   );

   config_frame_sequencer #(
      .NumberOfRows(NR),
      .FramesWrittenInit(16'hFFFE)
   ) dut_b (
      .CLK(clk),
      .reset(rst_b),
      .bus(ifb)
   );

   row_exp_t   qrow[$];
   frame_exp_t qframe[$];
   logic [15:0] qb[$];

   int errors = 0;
   int checks = 0;
   logic [15:0] frames_a = 16'h0000;
   logic [15:0] frames_b = 16'hFFFE;
   logic [31:0] far_exp = 32'h0;
   bit b_on = 1'b0;

   function automatic logic [15:0] sat_inc(logic [15:0] x);
      return (x == 16'hFFFF) ? x : x + 16'd1;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic monitor();
      row_exp_t r;
      frame_exp_t f;
      logic [15:0] b;
      forever begin
         @(negedge clk);
         if (ifa.RowWriteStrobe === 1'b1) begin
            if (qrow.size() == 0) begin
               check("row_strobe_unexpected", {31'b0, ifa.RowWriteStrobe}, 0);
            end else begin
               r = qrow.pop_front();
               check("row_select", {27'b0, ifa.RowSelect}, {27'b0, r.row});
               check("row_data", ifa.RowWriteData, r.data);
            end
         end
         if (ifa.LongFrameStrobe === 1'b1) begin
            if (qframe.size() == 0) begin
               check("frame_strobe_unexpected", {31'b0, ifa.LongFrameStrobe}, 0);
            end else begin
               f = qframe.pop_front();
               check("frame_addr", ifa.FrameAddressRegister, f.far);
               check("frames_written", {16'b0, ifa.FramesWritten}, {16'b0, f.frames});
            end
         end
         if (ifb.LongFrameStrobe === 1'b1) begin
            if (qb.size() == 0) begin
               check("b_frame_unexpected", {31'b0, ifb.LongFrameStrobe}, 0);
            end else begin
               b = qb.pop_front();
               check("b_frames_written", {16'b0, ifb.FramesWritten}, {16'b0, b});
            end
         end
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(logic [31:0] w);
      ifa.WriteData   = w;
      ifa.WriteStrobe = 1'b1;
      @(negedge clk);
      ifa.WriteStrobe = 1'b0;
   endtask

   task automatic data(logic [31:0] w, int row, bit last);
      qrow.push_back('{row: 5'(row), data: w});
      if (last) begin
         frames_a = sat_inc(frames_a);
         qframe.push_back('{far: far_exp, frames: frames_a});
         if (b_on) begin
            frames_b = sat_inc(frames_b);
            qb.push_back(frames_b);
         end
      end
      send(w);
      check("row_strobe_n1", {31'b0, ifa.RowWriteStrobe}, 1);
      if (last) begin
         check("lfs_n1", {31'b0, ifa.LongFrameStrobe}, 0);
         tick(1);
         check("lfs_n2", {31'b0, ifa.LongFrameStrobe}, 1);
         tick(1);
         check("lfs_n3", {31'b0, ifa.LongFrameStrobe}, 0);
      end else begin
         tick(2);
      end
   endtask

   task automatic frame(logic [31:0] addr, logic [31:0] base);
      send(addr);
      tick(2);
      far_exp = addr;
      for (int i = 0; i < NR; i++) begin
         data(base + 32'(i), i, i == NR - 1);
      end
   endtask

   task automatic check_reset_a(string tag);
      check({tag, "_active"}, {31'b0, ifa.Active}, 0);
      check({tag, "_error"}, {31'b0, ifa.Error}, 0);
      check({tag, "_rowsel"}, {27'b0, ifa.RowSelect}, 32'h1F);
      check({tag, "_far"}, ifa.FrameAddressRegister, 0);
      check({tag, "_rwd"}, ifa.RowWriteData, 0);
      check({tag, "_frames"}, {16'b0, ifa.FramesWritten}, 0);
      check({tag, "_rws"}, {31'b0, ifa.RowWriteStrobe}, 0);
      check({tag, "_lfs"}, {31'b0, ifa.LongFrameStrobe}, 0);
   endtask

   initial begin
      ifa.WriteData   = '0;
      ifa.WriteStrobe = 1'b0;
      fork
         monitor();
      join_none
      @(negedge clk);
      tick(2);
      check_reset_a("reset");
      rst_a = 1'b0;
      tick(2);

      // garbage before sync is ignored
      send(32'h1234_5678);
      tick(2);
      send(32'hFFFF_FFFF);
      tick(2);
      check("garbage_active", {31'b0, ifa.Active}, 0);
      check("garbage_error", {31'b0, ifa.Error}, 0);
      send(SyncWordDefault);
      check("sync_active", {31'b0, ifa.Active}, 1);
      tick(2);

      frame(32'h0000_0003, 32'h0000_00A0);
      check("f1_far", ifa.FrameAddressRegister, 32'h3);
      check("f1_frames", {16'b0, ifa.FramesWritten}, 1);
      check("f1_active", {31'b0, ifa.Active}, 1);
      check("f1_rowsel_idle", {27'b0, ifa.RowSelect}, 32'h1F);

      send(DESYNC);
      tick(2);
      check("desync_active", {31'b0, ifa.Active}, 0);
      check("desync_far", ifa.FrameAddressRegister, 32'h3);

      // back-to-back strobes in DATA
      send(SyncWordDefault);
      tick(2);
      send(32'h0000_0040);
      tick(2);
      far_exp = 32'h40;
      qrow.push_back('{row: 5'd0, data: 32'h0000_00B0});
      ifa.WriteData   = 32'h0000_00B0;
      ifa.WriteStrobe = 1'b1;
      @(negedge clk);
      ifa.WriteData   = 32'h0000_00B1;
      @(negedge clk);
      ifa.WriteStrobe = 1'b0;
      check("drop_error", {31'b0, ifa.Error}, 1);
      check("drop_no_strobe", {31'b0, ifa.RowWriteStrobe}, 0);
      tick(2);
      data(32'h0000_00C1, 1, 1'b0);
      data(32'h0000_00C2, 2, 1'b0);
      data(32'h0000_00C3, 3, 1'b1);
      check("drop_error_sticky", {31'b0, ifa.Error}, 1);
      send(DESYNC);
      tick(2);
      check("desync2_active", {31'b0, ifa.Active}, 0);
      check("desync2_far", ifa.FrameAddressRegister, 32'h40);
      check("desync2_error", {31'b0, ifa.Error}, 1);
      send(SyncWordDefault);
      check("resync_error_clr", {31'b0, ifa.Error}, 0);
      check("resync_active", {31'b0, ifa.Active}, 1);
      tick(2);

      // reset with half a frame loaded
      send(32'h0000_0055);
      tick(2);
      far_exp = 32'h55;
      data(32'h0000_00D0, 0, 1'b0);
      data(32'h0000_00D1, 1, 1'b0);
      rst_a = 1'b1;
      tick(1);
      check_reset_a("midreset");
      rst_a = 1'b0;
      frames_a = 16'h0000;
      tick(3);
      send(SyncWordDefault);
      tick(2);
      frame(32'h0000_0007, 32'h0000_00E0);
      check("after_reset_frames", {16'b0, ifa.FramesWritten}, 1);

      // saturation on the preloaded instance
      send(DESYNC);
      tick(2);
      check("sat_a_idle", {31'b0, ifa.Active}, 0);
      rst_b = 1'b0;
      b_on = 1'b1;
      tick(1);
      check("b_init", {16'b0, ifb.FramesWritten}, 32'hFFFE);
      send(SyncWordDefault);
      tick(2);
      for (int k = 0; k < 3; k++) begin
         frame(32'h0000_0009, 32'h0000_00F0 + 32'(k * 16));
      end
      check("b_saturated", {16'b0, ifb.FramesWritten}, 32'hFFFF);
      check("a_frames_final", {16'b0, ifa.FramesWritten}, 4);

      tick(4);
      check("qrow_empty", qrow.size(), 0);
      check("qframe_empty", qframe.size(), 0);
      check("qb_empty", qb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/config_frame_sequencer.md
Name: config_frame_sequencer

Overview:
- Sequences the configuration word stream (ConfigWriteData/ConfigWriteStrobe from the config port block) into fabric frame writes.
- Detects the sync word, latches the frame address, and steers each following word to one row via RowSelect and RowWriteStrobe.
- Closes each frame with a one-cycle LongFrameStrobe.
- Sits between the config port block and the per-row frame data registers / per-column frame select logic in the eFPGA top.

Parameters:
- NumberOfRows, 16: fabric rows that receive one 32-bit word per frame.
- FrameBitsPerRow, 32: word width; fixed at 32.
- RowSelectWidth, 5: width of RowSelect; must satisfy 2**RowSelectWidth > NumberOfRows.
- DesyncBit, 20: bit of an address word that, when set, ends configuration.
- SyncWord, 32'hFAB0_FAB1: word that starts a configuration session.

Ports:
- CLK  in  1  single clock for all state
- reset  in  1  synchronous, active-high reset
- WriteData  in  32  configuration word
- WriteStrobe  in  1  one-cycle qualifier for WriteData
- FrameAddressRegister  out  32  latched frame address word
- LongFrameStrobe  out  1  one-cycle pulse: a complete frame is loaded
- RowSelect  out  RowSelectWidth  target row of the current word; all-ones when idle
- RowWriteData  out  32  registered copy of the data word
- RowWriteStrobe  out  1  one-cycle pulse qualifying RowSelect/RowWriteData
- Active  out  1  high while synced (state != IDLE)
- FramesWritten  out  16  count of completed frames, saturating
- Error  out  1  sticky protocol-error flag

Behaviour:
- Reset values (synchronous reset, active-high):
  - state = IDLE.
  - FrameAddressRegister = 0, RowWriteData = 0.
  - RowSelect = all-ones.
  - LongFrameStrobe, RowWriteStrobe, Active, Error = 0.
  - FramesWritten = 0, row counter = 0.
  - All registered outputs; no combinational input-to-output paths.
- State IDLE:
  - WriteStrobe with WriteData == SyncWord -> ADDR; clears Error.
  - Any other word is ignored; no flags change.
- State ADDR, on WriteStrobe:
  - If WriteData[DesyncBit] = 1: -> IDLE; FrameAddressRegister is unchanged.
  - Otherwise: FrameAddressRegister <= WriteData, row counter <= 0, -> DATA.
- State DATA, on WriteStrobe at cycle n:
  - At n+1: RowWriteData = word, RowSelect = row counter, RowWriteStrobe = 1.
  - Row counter increments.
  - The word with row counter == NumberOfRows-1 is the last row. It moves the state to ADDR at n+1, and LongFrameStrobe = 1 at n+2, exactly one cycle.
  - FramesWritten increments at n+2 and saturates at 16'hFFFF.
- Output holding between events:
  - RowSelect holds its last value between strobes while in DATA.
  - RowSelect returns to all-ones on entering IDLE or ADDR.
  - RowWriteStrobe and LongFrameStrobe are zero whenever not pulsing.
- Strobe spacing:
  - WriteStrobe must be at least 2 cycles apart.
  - A strobe in the cycle directly after an accepted strobe is dropped: no state change, no output pulse, Error <= 1.
  - This guarantees FrameAddressRegister is stable through LongFrameStrobe.
- SyncWord while in ADDR or DATA:
  - Treated as an ordinary word (an address or row data); no resync.
- Partial frames:
  - Reset mid-frame discards the partial frame: no LongFrameStrobe, FramesWritten unchanged.
  - A desync is only recognised in ADDR, so a partial frame can only be ended by reset.
- Active is high in ADDR and DATA.

Decomposition:
- Shared package config_pkg:
  - state enum {IDLE, ADDR, DATA}.
  - Default SyncWord and DesyncBit constants.
  - FrameBitsPerRow constant.
  - All are shared with the config port block and the frame data register logic.
- No sub-module: one FSM plus the row counter, strobe-spacing tracker and frame counter fit in a single module.

Test Plan:
- Basic frame, NumberOfRows=4: sync, addr 32'h0000_0003, then data 32'hA0..A3 spaced 3 cycles apart -> RowWriteStrobe x4 with RowSelect 0,1,2,3 and matching data; LongFrameStrobe one cycle, 2 cycles after the last word; FrameAddressRegister = 32'h3; FramesWritten = 1.
- Pre-sync garbage: words 32'h1234_5678 and 32'hFFFF_FFFF while IDLE -> no strobes, Active = 0, Error = 0; then SyncWord -> Active = 1 next cycle.
- Desync: after one complete frame, send address 32'h0010_0000 (bit 20 set) -> state IDLE, Active = 0, FrameAddressRegister keeps the previous value, no LongFrameStrobe.
- Back-to-back strobes in DATA (cycles n, n+1) -> only the n word is written, Error = 1, row counter advances by 1; the next SyncWord after desync clears Error.
- Reset mid-frame after 2 of 4 data words -> all outputs return to reset values next cycle, no LongFrameStrobe; a new session then starts at row 0.
- FramesWritten preloaded to 16'hFFFE, then 3 complete frames -> counter reads 16'hFFFF and holds; LongFrameStrobe still pulses for each frame.
